wb_master_xactor: RTL and testbench

//   Synthesizable Wishbone classic-cycle master engine for the wb interface package (HDL side).

---
 rtl/wb_master_xactor.sv | 175 +++++++++++++++++
 tb/tb_wb_master_xactor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_xactor.sv
// -----------------------------------------------------------------------------
// wb_master_xactor
//   Wishbone classic single-cycle master engine. It takes one request on a
//   valid/ready command port and runs one Wishbone cycle. It then returns the
//   read data and status on a valid/ready response port. Only one transaction
//   is outstanding at a time.
//
//   Optional feature macro: WB_MASTER_TIMEOUT_EN
//     When this macro is defined, a BUS cycle that gets no ack/err within
//     TIMEOUT_CYCLES edges is ended as an error, with rsp_timeout=1.
//     When it is undefined, the engine waits in BUS indefinitely.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           command handshake
//   req_we/adr/dat/sel            command fields
//   rsp_valid/rsp_ready           response handshake
//   rsp_dat/rsp_err/rsp_timeout   response fields
//   wb_cyc_o..wb_sel_o            Wishbone master outputs
//   wb_dat_i/wb_ack_i/wb_err_i    Wishbone slave returns
//   spurious_cnt                  saturating count of ack/err seen outside BUS
// -----------------------------------------------------------------------------
module wb_master_xactor #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int SEL_W         = WB_DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [WB_ADDR_WIDTH-1:0] req_adr,
    input  logic [WB_DATA_WIDTH-1:0] req_dat,
    input  logic [SEL_W-1:0]         req_sel,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WB_DATA_WIDTH-1:0] rsp_dat,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    output logic [SEL_W-1:0]         wb_sel_o,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    output logic [7:0]               spurious_cnt
);

    // state | meaning
    // IDLE  | ready for a request; req_ready=1
    // BUS   | Wishbone cycle in progress; cyc=stb=1
    // RESP  | response presented; waiting for rsp_ready
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUS = 2'd1, ST_RESP = 2'd2} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t r_state;
    state_t w_next;

    logic                     w_accept;
    logic                     w_timeout;
    logic                     w_bus_end;
    logic                     r_we;
    logic [WB_ADDR_WIDTH-1:0] r_adr;
    logic [WB_DATA_WIDTH-1:0] r_dat;
    logic [SEL_W-1:0]         r_sel;
    logic [WB_DATA_WIDTH-1:0] r_rsp_dat;
    logic                     r_rsp_err;
    logic                     r_rsp_timeout;
    logic [7:0]               r_spur_cnt;

    assign w_accept  = req_valid && req_ready;
    assign w_bus_end = (r_state == ST_BUS) && (wb_ack_i || wb_err_i || w_timeout);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;

    // Down-counter is loaded on acceptance, so it reaches zero on the
    // TIMEOUT_CYCLES-th BUS edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
        end else if (r_state == ST_BUS && r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
        end
    end

    // An ack or err on the terminal edge wins over the timeout.
    assign w_timeout = (r_state == ST_BUS) && (r_tmo_cnt == '0) && !wb_ack_i && !wb_err_i;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)               w_next = ST_BUS;
            ST_BUS:  if (w_bus_end)              w_next = ST_RESP;
            ST_RESP: if (rsp_ready)              w_next = ST_IDLE;
            default:                             w_next = ST_IDLE;
        endcase
    end

    // cyc/stb follow the state register directly. This lets them fall
    // together with an asynchronous reset.
    always_comb begin
        req_ready = (r_state == ST_IDLE) && rst_n;
        wb_cyc_o  = (r_state == ST_BUS);
        wb_stb_o  = (r_state == ST_BUS);
        rsp_valid = (r_state == ST_RESP);
    end

    // Bus fields keep their last values after the cycle ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= '0;
        end else if (w_accept) begin
            r_we  <= req_we;
            r_adr <= req_adr;
            r_dat <= req_dat;
            r_sel <= req_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_dat     <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_bus_end) begin
            r_rsp_err     <= wb_err_i || w_timeout;
            r_rsp_timeout <= w_timeout;
            r_rsp_dat     <= (wb_ack_i && !wb_err_i && !r_we) ? wb_dat_i : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spur_cnt <= 8'd0;
        end else if (r_state != ST_BUS && (wb_ack_i || wb_err_i) && r_spur_cnt != 8'hFF) begin
            r_spur_cnt <= r_spur_cnt + 8'd1;
        end
    end

    assign wb_we_o      = r_we;
    assign wb_adr_o     = r_adr;
    assign wb_dat_o     = r_dat;
    assign wb_sel_o     = r_sel;
    assign rsp_dat      = r_rsp_dat;
    assign rsp_err      = r_rsp_err;
    assign rsp_timeout  = r_rsp_timeout;
    assign spurious_cnt = r_spur_cnt;

endmodule

// File: tb/tb_wb_master_xactor.sv
// -----------------------------------------------------------------------------
// tb_wb_master_xactor
//   Directed and randomized bench for wb_master_xactor.
//   Expected responses come from the Wishbone termination rules:
//     - err (or err together with ack) gives err=1 and data 0.
//     - a write gives data 0.
//     - a read with ack gives the slave data.
//   The spurious-pulse count is tracked as a saturating integer.
// -----------------------------------------------------------------------------
module tb_wb_master_xactor;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_dat;
    logic [SW-1:0] req_sel;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err, rsp_timeout;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i, wb_err_i;
    logic [7:0]    spurious_cnt;

    int checks   = 0;
    int failures = 0;
    int spur_exp = 0;

    always #5 clk = ~clk;

    wb_master_xactor #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .spurious_cnt(spurious_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spur_pulse(input logic use_err);
        wb_ack_i = !use_err;
        wb_err_i = use_err;
        step();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        spur_exp = (spur_exp < 255) ? spur_exp + 1 : 255;
        chk("spurious_cnt", {24'd0, spurious_cnt}, spur_exp);
    endtask

    // Issue one request at the current (idle) cycle.
    task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel);
        chk("req_ready_idle", {31'd0, req_ready}, 1);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
        step();
        req_valid = 1'b0; req_we = $urandom; req_adr = $urandom; req_dat = DW'($urandom);
        req_sel = SW'($urandom);
        chk("cyc_start", {31'd0, wb_cyc_o}, 1);
        chk("stb_start", {31'd0, wb_stb_o}, 1);
        chk("we_out", {31'd0, wb_we_o}, {31'd0, we});
        chk("adr_out", wb_adr_o, adr);
        chk("dat_out", {16'd0, wb_dat_o}, {16'd0, dat});
        chk("sel_out", {30'd0, wb_sel_o}, {30'd0, sel});
        chk("req_ready_bus", {31'd0, req_ready}, 0);
    endtask

    // Check the held response for 'hold' cycles, then consume it.
    task automatic consume(input logic [DW-1:0] e_dat, input logic e_err, input logic e_tmo,
                           input int hold);
        chk("cyc_end", {31'd0, wb_cyc_o}, 0);
        chk("stb_end", {31'd0, wb_stb_o}, 0);
        for (int i = 0; i < hold + 1; i++) begin
            if (i > 0) step();
            chk("rsp_valid", {31'd0, rsp_valid}, 1);
            chk("rsp_dat", {16'd0, rsp_dat}, {16'd0, e_dat});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
            chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e_tmo});
            chk("req_ready_resp", {31'd0, req_ready}, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_done", {31'd0, rsp_valid}, 0);
        chk("req_ready_after", {31'd0, req_ready}, 1);
        chk("spurious_hold", {24'd0, spurious_cnt}, spur_exp);
    endtask

    task automatic do_xact(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [SW-1:0] sel, input int waits, input logic ack,
                           input logic err, input logic [DW-1:0] din, input int hold);
        logic [DW-1:0] e_dat;
        e_dat = (err || we) ? '0 : din;
        issue(we, adr, dat, sel);
        for (int i = 0; i < waits; i++) begin
            step();
            chk("cyc_wait", {31'd0, wb_cyc_o}, 1);
            chk("adr_hold", wb_adr_o, adr);
            chk("rsp_valid_wait", {31'd0, rsp_valid}, 0);
        end
        wb_ack_i = ack; wb_err_i = err; wb_dat_i = din;
        step();
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = DW'($urandom);
        chk("we_hold_after", {31'd0, wb_we_o}, {31'd0, we});
        consume(e_dat, err, 1'b0, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
        rsp_ready = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 0);
        chk("rst_cyc", {31'd0, wb_cyc_o}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("post_rst_req_ready", {31'd0, req_ready}, 1);
        chk("post_rst_cyc", {31'd0, wb_cyc_o}, 0);
        chk("post_rst_adr", wb_adr_o, 0);
        chk("post_rst_spur", {24'd0, spurious_cnt}, 0);

        // T1 write, ack one cycle after cyc rises
        do_xact(1'b1, 32'h1000, 16'hBEEF, 2'b11, 1, 1'b1, 1'b0, 16'h5555, 0);
        // T2 zero-wait read
        do_xact(1'b0, 32'h0004, 16'h0000, 2'b11, 0, 1'b1, 1'b0, 16'h1234, 0);
        // T3 read with a stalled response consumer
        do_xact(1'b0, 32'h0008, 16'h0000, 2'b01, 2, 1'b1, 1'b0, 16'hA5C3, 5);
        // T4 ack and err together, then a spurious ack in IDLE
        do_xact(1'b0, 32'h000C, 16'h0000, 2'b10, 1, 1'b1, 1'b1, 16'h7777, 0);
        spur_pulse(1'b0);
        // ack on the last edge before a timeout would fire is a normal end
        do_xact(1'b0, 32'h0010, 16'h0000, 2'b11, TMO - 1, 1'b1, 1'b0, 16'h4242, 0);

        // T5 no ack from the slave
        issue(1'b0, 32'h0020, 16'h0000, 2'b11);
`ifdef WB_MASTER_TIMEOUT_EN
        for (int i = 0; i < TMO - 1; i++) begin
            step();
            chk("cyc_until_timeout", {31'd0, wb_cyc_o}, 1);
        end
        step();
        consume(16'h0000, 1'b1, 1'b1, 1);
`else
        begin
            int drops;
            drops = 0;
            for (int i = 0; i < 100; i++) begin
                step();
                if (!wb_cyc_o) drops++;
            end
            chk("cyc_no_timeout", drops, 0);
        end
        wb_ack_i = 1'b1; wb_dat_i = 16'h9999;
        step();
        wb_ack_i = 1'b0;
        consume(16'h9999, 1'b0, 1'b0, 0);
`endif

        // T6 reset in the middle of a wait-stated read
        issue(1'b0, 32'h0030, 16'h0000, 2'b11);
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        spur_exp = 0;
        chk("midrst_cyc", {31'd0, wb_cyc_o}, 0);
        chk("midrst_stb", {31'd0, wb_stb_o}, 0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("midrst_spur", {24'd0, spurious_cnt}, 0);
        step(); step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("after_rst_no_rsp", {31'd0, rsp_valid}, 0);
            chk("after_rst_no_cyc", {31'd0, wb_cyc_o}, 0);
        end
        do_xact(1'b0, 32'h0034, 16'h0000, 2'b11, 1, 1'b1, 1'b0, 16'hCAFE, 0);

        // Randomized transactions against the termination rules
        for (int n = 0; n < 25; n++) begin
            int kind;
            logic a, e;
            if ($urandom_range(0, 3) == 0) spur_pulse(1'($urandom));
            kind = $urandom_range(0, 5);
            a = (kind != 4);
            e = (kind >= 4);
            do_xact(1'($urandom), $urandom, DW'($urandom), SW'($urandom), $urandom_range(0, 4),
                    a, e, DW'($urandom), $urandom_range(0, 3));
        end

        // Spurious counter saturation
        for (int i = 0; i < 260; i++) spur_pulse(1'(i % 2));
        chk("spur_saturated", {24'd0, spurious_cnt}, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
